// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-master data-RAM arbiter:
//   - default parameter values (address/data width, starvation limit)
//   - base word address of the register window that master 1 may not write
//   - FSM state encoding (3-bit)
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 4;

  // First word address of the register window.
  localparam logic [10:0] REG_BASE = 11'h200;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_ACK     = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

endpackage : ram_arb_pkg

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the two master request/response ports, the RAM port and the busy
// flag of ram_arbiter.
//   slave  : arbiter side (takes requests and ram_rdata, drives acks/RAM)
//   master : environment side (masters plus the RAM)
// ---------------------------------------------------------------------------
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Master 0 (CPU datapath)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  // Master 1 (program loader / debug port)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  // Single-port RAM
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_ack, m0_rdata,
    output m1_ack, m1_rdata, m1_err,
    output ram_addr, ram_wdata, ram_we,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_ack, m0_rdata,
    input  m1_ack, m1_rdata, m1_err,
    input  ram_addr, ram_wdata, ram_we,
    input  busy
  );

endinterface : ram_arbiter_if

// File: rtl/ram_arb_prio.sv
// ---------------------------------------------------------------------------
// ram_arb_prio
// Winner select for the two masters. Master 0 wins by default; master 1 wins
// when master 0 is idle or after it has lost MAX_WAIT consecutive
// arbitrations.
// Ports:
//   clk, reset_bar : clock, synchronous active-low reset
//   m0_req_i       : master 0 request
//   m1_req_i       : master 1 request
//   arb_en_i       : high while the arbiter FSM is in IDLE
//   grant1_o       : 1 = master 1 wins this arbitration (combinational)
// ---------------------------------------------------------------------------
module ram_arb_prio
  import ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset_bar,
  input  logic m0_req_i,
  input  logic m1_req_i,
  input  logic arb_en_i,
  output logic grant1_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign grant1_o = m1_req_i && (!m0_req_i || (wait_cnt_q == MAX_CNT));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (arb_en_i) begin
      if (!m1_req_i || grant1_o) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != MAX_CNT) begin
        wait_cnt_d = wait_cnt_q + 4'd1;  // saturates at MAX_CNT
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset is synchronous and sits inside the
  // clocked block.
  always_ff @(posedge clk) begin
    if (!reset_bar) wait_cnt_q <= '0;
    else            wait_cnt_q <= wait_cnt_d;
  end

endmodule : ram_arb_prio

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Serializes two masters onto one single-port word-addressed data RAM and
// sequences each access to RAM timing (read data registered on the rising
// edge, writes committed on the falling edge). Master 1 may not write word
// addresses at or above REG_BASE; such writes complete with m1_err.
// Ports:
//   clk        : single clock, all state changes on the rising edge
//   reset_bar  : synchronous active-low reset
//   bus        : ram_arbiter_if.slave - master 0/1 request and response
//                signals, RAM address/data/write-enable, busy flag
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          reset_bar,
  ram_arbiter_if.slave  bus
);

  state_e            state_q;
  logic              owner_q;      // 1 = master 1 owns the current access
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic              m0_ack_q, m1_ack_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              busy_q;

  logic grant1;
  logic arb_en;
  logic m1_blocked;

  assign arb_en     = (state_q == ST_IDLE);
  assign m1_blocked = bus.m1_we && (bus.m1_addr >= ADDR_W'(REG_BASE));

  ram_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk      (clk),
    .reset_bar(reset_bar),
    .m0_req_i (bus.m0_req),
    .m1_req_i (bus.m1_req),
    .arb_en_i (arb_en),
    .grant1_o (grant1)
  );

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m1_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner_q <= grant1;
            busy_q  <= 1'b1;
            if (grant1 && m1_blocked) begin
              // Rejected write: the RAM port is left untouched.
              state_q  <= ST_ERR;
              m1_ack_q <= 1'b1;
              m1_err_q <= 1'b1;
            end else if (grant1) begin
              ram_addr_q  <= bus.m1_addr;
              ram_wdata_q <= bus.m1_wdata;
              ram_we_q    <= bus.m1_we;
              state_q     <= ST_ACCESS;
            end else begin
              ram_addr_q  <= bus.m0_addr;
              ram_wdata_q <= bus.m0_wdata;
              ram_we_q    <= bus.m0_we;
              state_q     <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          // ram_we_q still holds the granted direction during this cycle.
          ram_we_q <= 1'b0;
          if (ram_we_q) begin
            state_q  <= ST_ACK;
            m0_ack_q <= !owner_q;
            m1_ack_q <= owner_q;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (owner_q) m1_rdata_q <= bus.ram_rdata;
          else         m0_rdata_q <= bus.ram_rdata;
          m0_ack_q <= !owner_q;
          m1_ack_q <= owner_q;
          state_q  <= ST_ACK;
        end

        default: begin  // ST_ACK, ST_ERR
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.busy      = busy_q;

endmodule : ram_arbiter
